// File: rtl/compare_tree_sched_pkg.sv
// Shared helpers for the compare-tree scheduler: width/depth derivation used by
// the top, the round-robin arbiter and the comparator tree.
package compare_tree_sched_pkg;

  // Number of bits needed to represent value (0 -> 0, 1 -> 1, 29 -> 5).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/compare_rr_arbiter.sv
// Round-robin grant: searches from pointer+1 (mod NREQ) for the first eligible
// requester and returns a one-hot grant plus its encoded ID.
module compare_rr_arbiter
  import compare_tree_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = clogb2(NREQ - 1)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  pointer,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(pointer) + i) % NREQ;
      if (!grant_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/par_compare_tree.sv
// Pipelined unsigned max tree: one vector per clock, one register per level,
// result NSTAGE edges after the vector is presented.
module par_compare_tree
  import compare_tree_sched_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int ELEMENTS = 30
) (
  input  logic                      clk_i,
  input  logic [WIDTH*ELEMENTS-1:0] data_i,
  output logic [WIDTH-1:0]          max_o
);

  localparam int NSTAGE = clogb2(ELEMENTS - 1);
  localparam int PAD    = 1 << NSTAGE;
  localparam int PW     = PAD * WIDTH;

  function automatic logic [WIDTH-1:0] max2(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  // One tree level: pairwise max into the lower half, upper half zero.
  function automatic logic [PW-1:0] reduce(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < PAD / 2; i++)
      r[i*WIDTH +: WIDTH] = max2(v[2*i*WIDTH +: WIDTH], v[(2*i+1)*WIDTH +: WIDTH]);
    return r;
  endfunction

  logic [PW-1:0] lvl_in;
  logic [PW-1:0] lvl_p [1:NSTAGE];

  // Zero padding up to a power of two is neutral for an unsigned max.
  assign lvl_in = PW'(data_i);

  // Level boundaries p1..pNSTAGE
  always_ff @(posedge clk_i) begin
    lvl_p[1] <= reduce(lvl_in);
    for (int s = 2; s <= NSTAGE; s++)
      lvl_p[s] <= reduce(lvl_p[s-1]);
  end

  assign max_o = lvl_p[NSTAGE][WIDTH-1:0];

endmodule

// File: rtl/compare_tree_sched.sv
// Shares one pipelined max-compare tree between NREQ requesters; a tag pipe of
// the same depth as the data path carries the owner ID to the output strobe.
module compare_tree_sched
  import compare_tree_sched_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int ELEMENTS = 30,
  parameter  int NREQ     = 4,
  localparam int NSTAGE   = clogb2(ELEMENTS - 1),
  localparam int IDW      = clogb2(NREQ - 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NREQ-1:0]                req_i,
  input  logic [NREQ*WIDTH*ELEMENTS-1:0] vector_i,
  input  logic [NREQ-1:0]                mask_i,
  output logic [NREQ-1:0]                ack_o,
  output logic                           busy_o,
  output logic [WIDTH-1:0]               max_o,
  output logic                           max_valid_o,
  output logic [IDW-1:0]                 max_id_o
);

  localparam int VW = WIDTH * ELEMENTS;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic [IDW-1:0]   ptr;
  logic [VW-1:0]    vec_p0;
  logic [NSTAGE:0]  tag_vld;
  logic [IDW-1:0]   tag_id [NSTAGE+1];
  logic [WIDTH-1:0] tree_max;

  compare_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .eligible  (req_i & mask_i),
    .pointer   (ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Reset suppresses the acknowledge so a requester never sees a lost accept.
  assign ack_o  = rst_i ? '0 : grant;
  assign busy_o = |tag_vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr     <= IDW'(NREQ - 1);
      tag_vld <= '0;
    end else begin
      if (grant_any) ptr <= grant_id;
      tag_vld <= {tag_vld[NSTAGE-1:0], grant_any};
    end
  end

  // Acceptance boundary p0: input register and tag ID pipe (no reset on data)
  always_ff @(posedge clk_i) begin
    if (grant_any) vec_p0 <= vector_i[grant_id*VW +: VW];
    tag_id[0] <= grant_id;
    for (int s = 1; s <= NSTAGE; s++)
      tag_id[s] <= tag_id[s-1];
  end

  par_compare_tree #(.WIDTH(WIDTH), .ELEMENTS(ELEMENTS)) u_tree (
    .clk_i  (clk_i),
    .data_i (vec_p0),
    .max_o  (tree_max)
  );

  // Output boundary: result and owner captured together with the tag strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_valid_o <= 1'b0;
      max_o       <= '0;
      max_id_o    <= '0;
    end else begin
      max_valid_o <= tag_vld[NSTAGE];
      if (tag_vld[NSTAGE]) begin
        max_o    <= tree_max;
        max_id_o <= tag_id[NSTAGE];
      end
    end
  end

endmodule

// File: doc/compare_tree_sched.md
Name: compare_tree_sched

Overview:
- Shares one pipelined max-compare tree (par_compare_tree, one vector per clock) between NREQ requesters, e.g. per-channel peak search.
- A round-robin arbiter accepts at most one vector per clock; a tag pipeline tracks the owner through the tree.
- The registered maximum is returned with a valid strobe and the requester ID.
- Sits between the trigger/power-sum requesters and the shared comparator datapath.

Parameters:
- WIDTH, 4, bits per element.
- ELEMENTS, 30, elements per vector; must be >= 2.
- NREQ, 4, number of requesters; must be >= 2.
- NSTAGE, clogb2(ELEMENTS-1), derived localparam: tree stages (5 at default).
- IDW, clogb2(NREQ-1), derived localparam: ID width (2 at default).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- req_i  in  NREQ  per-requester request; held with its vector until acked.
- vector_i  in  NREQ*WIDTH*ELEMENTS  concatenated vectors; requester r occupies slice r.
- mask_i  in  NREQ  1 = requester enabled; a masked req_i is ignored.
- ack_o  out  NREQ  one-hot, combinational; high in the cycle the vector is sampled.
- busy_o  out  1  any result in flight.
- max_o  out  WIDTH  registered maximum.
- max_valid_o  out  1  one-cycle strobe qualifying max_o / max_id_o.
- max_id_o  out  IDW  requester that owns max_o.

Behaviour:
- Reset (async, rst_i=1):
  - ack_o=0, max_o=0, max_valid_o=0, max_id_o=0, busy_o=0.
  - Tag-valid pipeline cleared; RR pointer = NREQ-1, so requester 0 has first priority.
  - In-flight vectors are discarded and never produce max_valid_o.
  - Tree data registers are not reset.
- Arbitration:
  - eligible = req_i & mask_i.
  - Search starts at pointer+1, wrapping modulo NREQ; the first eligible requester g gets ack_o[g]=1.
  - ack_o is zero when nothing is eligible or rst_i is high.
- Acceptance edge E0 (ack_o[g]=1):
  - vector_i slice g goes into the input register.
  - tag {valid=1, id=g} goes into the tag pipe.
  - pointer <= g; the pointer is unchanged on idle cycles.
- Handshake:
  - Requester samples ack_o at the same edge. It may keep req_i high to present the next vector in the following cycle (back-to-back allowed).
  - Deasserting req_i without an ack withdraws the request; no state is kept.
- Latency:
  - Tree stages capture at E0+1..E0+NSTAGE.
  - Output register captures at E0+NSTAGE+1.
  - max_valid_o is high for the cycle after that edge: 6 edges at default.
- Tag pipe depth is NSTAGE+1, matching the data path exactly. There is no backpressure; the consumer must accept every strobe.
- Throughput: one result per clock when continuously fed; the order of results equals the order of acceptance.
- max_o / max_id_o hold their last values while max_valid_o=0.
- busy_o = OR of tag-pipe valid bits, combinational from registers.
- Compare: unsigned. Ties yield the equal value; owner ID is unaffected.
- mask_i changes take effect in the same cycle. Masking a requester does not cancel its in-flight results.
- Simultaneous reset and ack: reset wins and nothing is accepted.

Decomposition:
- Shared package / include: clogb2.vh for NSTAGE/IDW; a tag struct constant width IDW+1.
- Sub-module compare_rr_arbiter (NREQ): eligible, pointer -> one-hot grant + encoded ID.
- The tree itself is an instance of the existing par_compare_tree(WIDTH, ELEMENTS). Input, tag and output registers live in compare_tree_sched.

Test Plan:
- Defaults, requester 1 only, vector elements 0..29 = {3,7,2,...,9 at index 17,...} -> ack_o=4'b0010 one cycle; after 6 edges max_valid_o=1, max_o=9, max_id_o=1; busy_o high for the 6 intervening cycles.
- All four req_i held high for 8 cycles, vector r with max r+10 -> acks 0,1,2,3,0,1,2,3 on consecutive cycles; strobes on 8 consecutive cycles with ids 0,1,2,3,0,1,2,3 and max 10,11,12,13,10,11,12,13.
- mask_i=4'b1011 with all requests high -> requester 2 never acked; grant order 0,1,3,0.
- Accept three vectors, assert rst_i asynchronously mid-flight (between edges E0+2 and E0+3) -> outputs 0 immediately; no max_valid_o afterwards; next grant goes to requester 0.
- All-zero vector and all-15 vector from requester 3 -> max_o=0 then 15, id 3, consecutive strobes.
- Boundary ELEMENTS=2, NREQ=2 build: NSTAGE=1 -> result 2 edges after acceptance; alternating grants 0,1.
